// File: rtl/audio_note_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : audio_note_sequencer_if
//  Description : Bundle of note-table write port, sequence control and
//                oscillator-facing outputs of audio_note_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface audio_note_sequencer_if #(
    parameter int DEPTH  = 16,
    parameter int FREQ_W = 16,
    parameter int DUR_W  = 12
);
    logic                       wr_en_i;
    logic [$clog2(DEPTH)-1:0]   wr_addr_i;
    logic [FREQ_W-1:0]          wr_freq_i;
    logic [DUR_W-1:0]           wr_dur_i;
    logic [$clog2(DEPTH):0]     len_i;
    logic                       loop_i;
    logic                       start_i;
    logic                       stop_i;
    logic [FREQ_W-1:0]          freq_o;
    logic                       gate_o;
    logic                       busy_o;
    logic                       done_o;
    logic [$clog2(DEPTH)-1:0]   note_idx_o;

    // Controller side: programs the table and drives start/stop.
    modport master (
        output wr_en_i, wr_addr_i, wr_freq_i, wr_dur_i,
        output len_i, loop_i, start_i, stop_i,
        input  freq_o, gate_o, busy_o, done_o, note_idx_o
    );

    // Sequencer side.
    modport slave (
        input  wr_en_i, wr_addr_i, wr_freq_i, wr_dur_i,
        input  len_i, loop_i, start_i, stop_i,
        output freq_o, gate_o, busy_o, done_o, note_idx_o
    );
endinterface
`default_nettype wire

// File: rtl/audio_note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : audio_note_sequencer
//  Description : Plays a programmable table of (frequency, duration) notes
//                into a square-wave oscillator, with optional looping and a
//                one-cycle completion pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_note_sequencer #(
    parameter int DEPTH    = 16,
    parameter int FREQ_W   = 16,
    parameter int DUR_W    = 12,
    parameter int TICK_DIV = 1000
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    audio_note_sequencer_if.slave      bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LEN_W = IDX_W + 1;
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [FREQ_W-1:0]   freq_mem [DEPTH];
    logic [DUR_W-1:0]    dur_mem  [DEPTH];

    logic [IDX_W-1:0]    idx;
    logic [LEN_W-1:0]    len_q;
    logic [PRE_W-1:0]    presc;
    logic [DUR_W-1:0]    dur_cnt;
    logic [FREQ_W-1:0]   freq;
    logic                gate;
    logic                done;
    logic [IDX_W-1:0]    note_idx;

    logic                accept;
    logic                tick;
    logic                note_end;
    logic                last;
    logic [LEN_W-1:0]    len_clamped;
    logic [FREQ_W-1:0]   rd_freq;
    logic [DUR_W-1:0]    rd_dur;

    // Combinational read of the entry addressed by idx; the table is only
    // updated at the clock edge, so a same-cycle write yields the old data.
    assign rd_freq     = freq_mem[idx];
    assign rd_dur      = dur_mem[idx];
    assign len_clamped = (bus.len_i > DEPTH_LEN) ? DEPTH_LEN : bus.len_i;

    assign bus.freq_o     = freq;
    assign bus.gate_o     = gate;
    assign bus.done_o     = done;
    assign bus.note_idx_o = note_idx;
    assign bus.busy_o     = (state != IDLE);

    // Note-table write port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (bus.wr_en_i) begin
            freq_mem[bus.wr_addr_i] <= bus.wr_freq_i;
            dur_mem[bus.wr_addr_i]  <= bus.wr_dur_i;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the shared tick / note-end / last-entry decodes.
    always_comb begin
        state_next = state;
        accept     = (state == IDLE) && bus.start_i && !bus.stop_i &&
                     (bus.len_i != '0);
        tick       = (state == PLAY) && (presc == PRE_LAST);
        note_end   = tick && (dur_cnt == DUR_W'(1));
        // Wrap decision by compare, so any len_q up to DEPTH works.
        last       = ({1'b0, idx} == (len_q - LEN_W'(1)));
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = bus.stop_i ? IDLE : PLAY;
            end
            PLAY: begin
                // Abort outranks a note end in the same cycle.
                if (bus.stop_i) begin
                    state_next = IDLE;
                end else if (note_end) begin
                    state_next = (!last || bus.loop_i) ? LOAD : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: sequence position, tick prescaler, duration and outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx      <= '0;
            len_q    <= '0;
            presc    <= '0;
            dur_cnt  <= '0;
            freq     <= '0;
            gate     <= 1'b0;
            done     <= 1'b0;
            note_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    freq  <= '0;
                    gate  <= 1'b0;
                    presc <= '0;
                    if (accept) begin
                        len_q <= len_clamped;
                        idx   <= '0;
                    end
                end
                LOAD: begin
                    if (bus.stop_i) begin
                        freq <= '0;
                        gate <= 1'b0;
                    end else begin
                        freq     <= rd_freq;
                        gate     <= (rd_freq != '0);
                        // A zero duration still plays for one tick.
                        dur_cnt  <= (rd_dur == '0) ? DUR_W'(1) : rd_dur;
                        presc    <= '0;
                        note_idx <= idx;
                    end
                end
                PLAY: begin
                    if (bus.stop_i) begin
                        freq <= '0;
                        gate <= 1'b0;
                    end else begin
                        presc <= tick ? '0 : presc + PRE_W'(1);
                        if (note_end) begin
                            if (!last) begin
                                idx <= idx + IDX_W'(1);
                            end else if (bus.loop_i) begin
                                idx <= '0;
                            end else begin
                                freq <= '0;
                                gate <= 1'b0;
                                done <= 1'b1;
                            end
                        end else if (tick) begin
                            dur_cnt <= dur_cnt - DUR_W'(1);
                        end
                    end
                end
                default: begin
                    freq <= '0;
                    gate <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_audio_note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_note_sequencer
//  Description : Directed self-checking bench for audio_note_sequencer with
//                TICK_DIV=4. Sample index k is the value seen just after the
//                k-th rising edge following the edge that accepts start.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_note_sequencer;
    localparam int DEPTH    = 16;
    localparam int FREQ_W   = 16;
    localparam int DUR_W    = 12;
    localparam int TICK_DIV = 4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    audio_note_sequencer_if #(.DEPTH(DEPTH), .FREQ_W(FREQ_W), .DUR_W(DUR_W)) bus ();

    audio_note_sequencer #(
        .DEPTH(DEPTH), .FREQ_W(FREQ_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; return on the falling edge where outputs are stable.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_entry(input int addr, input int f, input int d);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = 4'(addr);
        bus.wr_freq_i = 16'(f);
        bus.wr_dur_i  = 12'(d);
        step();
        bus.wr_en_i   = 1'b0;
    endtask

    task automatic load_basic_table();
        write_entry(0, 100, 2);
        write_entry(1, 0, 1);
        write_entry(2, 300, 3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests++;
        if (bus.freq_o !== 16'd0 || bus.gate_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.done_o !== 1'b0 || bus.note_idx_o !== 4'd0) begin
            fails++;
            $display("FAIL reset freq=%0d gate=%0b busy=%0b done=%0b idx=%0d (want all 0)",
                     bus.freq_o, bus.gate_o, bus.busy_o, bus.done_o, bus.note_idx_o);
        end
        rst = 1'b0;
        step();
    endtask

    // Three-note sequence; optionally pulses start (with another len) while busy.
    task automatic test_basic(input bit poke_start);
        int ef;
        bit eb, ed;
        load_basic_table();
        bus.len_i   = 5'd3;
        bus.loop_i  = 1'b0;
        bus.start_i = 1'b1;
        for (int k = 0; k <= 28; k++) begin
            step();
            ef = (k >= 1 && k <= 9) ? 100 : (k >= 15 && k <= 26) ? 300 : 0;
            eb = (k <= 26);
            ed = (k == 27);
            tests++;
            if (bus.freq_o !== 16'(ef) || bus.gate_o !== (ef != 0) ||
                bus.busy_o !== eb || bus.done_o !== ed) begin
                fails++;
                $display("FAIL %s k=%0d freq=%0d want %0d gate=%0b busy=%0b want %0b done=%0b want %0b",
                         poke_start ? "start_busy" : "basic", k, bus.freq_o, ef,
                         bus.gate_o, bus.busy_o, eb, bus.done_o, ed);
            end
            bus.start_i = 1'b0;
            if (poke_start && (k == 5 || k == 20)) begin
                bus.start_i = 1'b1;
                bus.len_i   = 5'd1;
            end
        end
        bus.start_i = 1'b0;
    endtask

    // Looping pass, then loop dropped during entry1 of the second pass.
    task automatic test_loop();
        int ef;
        bit eb, ed;
        load_basic_table();
        bus.len_i   = 5'd3;
        bus.loop_i  = 1'b1;
        bus.start_i = 1'b1;
        for (int k = 0; k <= 56; k++) begin
            step();
            ef = ((k >= 1 && k <= 9) || (k >= 28 && k <= 36)) ? 100 :
                 ((k >= 15 && k <= 27) || (k >= 42 && k <= 53)) ? 300 : 0;
            eb = (k <= 53);
            ed = (k == 54);
            tests++;
            if (bus.freq_o !== 16'(ef) || bus.gate_o !== (ef != 0) ||
                bus.busy_o !== eb || bus.done_o !== ed) begin
                fails++;
                $display("FAIL loop k=%0d freq=%0d want %0d gate=%0b busy=%0b want %0b done=%0b want %0b",
                         k, bus.freq_o, ef, bus.gate_o, bus.busy_o, eb, bus.done_o, ed);
            end
            bus.start_i = 1'b0;
            if (k == 38) bus.loop_i = 1'b0;
        end
    endtask

    task automatic test_zero_dur();
        int ef;
        write_entry(0, 50, 0);
        bus.len_i   = 5'd1;
        bus.loop_i  = 1'b0;
        bus.start_i = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            step();
            bus.start_i = 1'b0;
            ef = (k >= 1 && k <= 4) ? 50 : 0;
            tests++;
            if (bus.freq_o !== 16'(ef) || bus.busy_o !== (k <= 4) ||
                bus.done_o !== (k == 5)) begin
                fails++;
                $display("FAIL zero_dur k=%0d freq=%0d want %0d busy=%0b done=%0b",
                         k, bus.freq_o, ef, bus.busy_o, bus.done_o);
            end
        end
    endtask

    task automatic test_stop();
        load_basic_table();
        bus.len_i   = 5'd3;
        bus.loop_i  = 1'b0;
        bus.start_i = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            step();
            bus.start_i = 1'b0;
        end
        tests++;
        if (bus.freq_o !== 16'd300) begin
            fails++;
            $display("FAIL stop_pre freq=%0d want 300", bus.freq_o);
        end
        bus.stop_i = 1'b1;
        step();
        bus.stop_i = 1'b0;
        tests++;
        if (bus.freq_o !== 16'd0 || bus.gate_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.done_o !== 1'b0) begin
            fails++;
            $display("FAIL stop freq=%0d gate=%0b busy=%0b done=%0b (want all 0)",
                     bus.freq_o, bus.gate_o, bus.busy_o, bus.done_o);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            tests++;
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                fails++;
                $display("FAIL stop_after k=%0d done=%0b busy=%0b want 0/0",
                         k, bus.done_o, bus.busy_o);
            end
        end
        // start and stop together in IDLE: stop wins
        bus.start_i = 1'b1;
        bus.stop_i  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            tests++;
            if (bus.busy_o !== 1'b0) begin
                fails++;
                $display("FAIL start_stop k=%0d busy=%0b want 0", k, bus.busy_o);
            end
        end
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        step();
    endtask

    task automatic test_len_zero();
        bus.len_i   = 5'd0;
        bus.start_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.freq_o !== 16'd0) begin
                fails++;
                $display("FAIL len_zero k=%0d busy=%0b done=%0b freq=%0d want 0/0/0",
                         k, bus.busy_o, bus.done_o, bus.freq_o);
            end
        end
        bus.start_i = 1'b0;
    endtask

    // len 20 clamps to 16 entries of one tick each: 5 samples per entry.
    task automatic test_len_clamp();
        for (int i = 0; i < DEPTH; i++) write_entry(i, 10 * i + 10, 1);
        bus.len_i   = 5'd20;
        bus.loop_i  = 1'b0;
        bus.start_i = 1'b1;
        for (int k = 0; k <= 81; k++) begin
            step();
            bus.start_i = 1'b0;
            if (k == 76) begin
                tests++;
                if (bus.note_idx_o !== 4'd15 || bus.freq_o !== 16'd160) begin
                    fails++;
                    $display("FAIL clamp_last idx=%0d freq=%0d want 15/160",
                             bus.note_idx_o, bus.freq_o);
                end
            end
            if (k == 41) begin
                tests++;
                if (bus.note_idx_o !== 4'd8 || bus.freq_o !== 16'd90) begin
                    fails++;
                    $display("FAIL clamp_mid idx=%0d freq=%0d want 8/90",
                             bus.note_idx_o, bus.freq_o);
                end
            end
            if (k == 80) begin
                tests++;
                if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0) begin
                    fails++;
                    $display("FAIL clamp_done done=%0b busy=%0b want 1/0",
                             bus.done_o, bus.busy_o);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        load_basic_table();
        bus.len_i   = 5'd3;
        bus.loop_i  = 1'b0;
        bus.start_i = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            step();
            bus.start_i = 1'b0;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if (bus.freq_o !== 16'd0 || bus.gate_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.done_o !== 1'b0 || bus.note_idx_o !== 4'd0) begin
            fails++;
            $display("FAIL reset_mid freq=%0d gate=%0b busy=%0b done=%0b idx=%0d (want all 0)",
                     bus.freq_o, bus.gate_o, bus.busy_o, bus.done_o, bus.note_idx_o);
        end
        step();
    endtask

    // Overwrite entry1 during its LOAD cycle: old value now, new one next pass.
    task automatic test_rbw();
        int ef;
        write_entry(0, 100, 1);
        write_entry(1, 200, 1);
        bus.len_i   = 5'd2;
        bus.loop_i  = 1'b1;
        bus.start_i = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            step();
            bus.start_i = 1'b0;
            bus.wr_en_i = 1'b0;
            ef = ((k >= 1 && k <= 5) || (k >= 11 && k <= 15)) ? 100 :
                 (k >= 6 && k <= 10) ? 200 : (k >= 16) ? 222 : 0;
            tests++;
            if (bus.freq_o !== 16'(ef)) begin
                fails++;
                $display("FAIL rbw k=%0d freq=%0d want %0d", k, bus.freq_o, ef);
            end
            if (k == 5) begin
                bus.wr_en_i   = 1'b1;
                bus.wr_addr_i = 4'd1;
                bus.wr_freq_i = 16'd222;
                bus.wr_dur_i  = 12'd1;
            end
        end
        bus.loop_i = 1'b0;
        bus.stop_i = 1'b1;
        step();
        bus.stop_i = 1'b0;
        step();
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        rst           = 1'b1;
        bus.wr_en_i   = 1'b0;
        bus.wr_addr_i = '0;
        bus.wr_freq_i = '0;
        bus.wr_dur_i  = '0;
        bus.len_i     = '0;
        bus.loop_i    = 1'b0;
        bus.start_i   = 1'b0;
        bus.stop_i    = 1'b0;
        step();
        test_reset();
        test_basic(1'b0);
        test_loop();
        test_zero_dur();
        test_stop();
        test_len_zero();
        test_len_clamp();
        test_basic(1'b1);
        test_reset_mid();
        test_rbw();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
